alu_decode_stage: RTL
=====================

# alu_decode_stage

Registered decode stage between the instruction fetch path and the ALU of the eBPF soft CPU. It accepts raw 64-bit eBPF instructions over a valid/ready handshake. It produces the ALU control code, the 32/64-bit mode, register indices and a sign-extended immediate, and flags illegal ALU encodings. A two-entry skid buffer gives full throughput with fully registered ready.

## Interface
- No parameters; instruction width fixed at 64.
- `clk`  in  1  sole clock
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  instruction offered
- `in_ready`  out  1  stage can accept; driven directly from a flop
- `in_insn`  in  64  eBPF instruction: `[7:0]` opcode, `[11:8]` dst, `[15:12]` src, `[31:16]` offset, `[63:32]` imm
- `out_valid`  out  1  decoded result valid
- `out_ready`  in  1  consumer accepts
- `out_is_alu`  out  1  opcode class is ALU (`3'h4`) or ALU64 (`3'h7`)
- `out_alu_control`  out  4  ALU control code (`4'h0`..`4'he`)
- `out_is_32bit`  out  1  32-bit operation
- `out_use_imm`  out  1  operand B comes from the immediate
- `out_dst_reg`, `out_src_reg`  out  4  register indices
- `out_imm64`  out  64  sign-extended imm
- `out_illegal`  out  1  illegal ALU encoding
- `illegal_count`  out  16  count of illegal instructions delivered; saturates at `16'hFFFF`

## Operation
- Decode, with `op = insn[7:4]`, `src bit = insn[3]`, `class = insn[2:0]`:
  - `op` `0x0`–`0xc` maps directly to `out_alu_control` (ADD, SUB, MUL, DIV, OR, AND, LSH, RSH, NEG, MOD, XOR, MOV, ARSH).
  - END (`op` = `0xd`): src bit 0 gives `4'hd` (LE); src bit 1 gives `4'he` (BE).
- `out_is_32bit = (class == 3'h4)`, except END, which always drives 0.
- `out_use_imm = ~src bit` for non-END ops. END drives `use_imm = 1` and `imm64 = 16/32/64`.
- `out_imm64 = {{32{imm[31]}}, imm}` for every instruction.
- Non-ALU classes: `is_alu = 0`, `illegal = 0`, other fields decoded as above. The instruction passes through unchanged in order.
- `out_illegal = 1` (only when `is_alu = 1`) if any of the following holds:
  - `op` is `0xe` or `0xf`
  - END in class ALU64
  - END with imm not in {16, 32, 64}
  - `dst > 9`
  - src bit = 1 and `src > 10`
- `illegal_count` increments on the output handshake (`out_valid & out_ready`) of an illegal instruction.

## Timing
- Reset values: `in_ready = 1`, `out_valid = 0`, `illegal_count = 0`. All data outputs reset to 0. Reset mid-transfer discards both buffer entries.
- Latency: 1 cycle. An instruction accepted at edge N appears on the outputs after edge N, when `out_valid` is set.
- Occupancy states:
  - EMPTY: `out_valid = 0`, `in_ready = 1`.
  - ONE: main register valid, `in_ready = 1`.
  - TWO: main and skid valid, `in_ready = 0`.
- Transitions:
  - EMPTY → ONE on accept.
  - ONE → ONE on simultaneous accept and handshake.
  - ONE → TWO on accept with `out_ready = 0`.
  - ONE → EMPTY on handshake with no accept.
  - TWO → ONE on handshake; skid moves to main. No accept is possible in TWO.
- Outputs are stable while `out_valid & ~out_ready`.
- Strict FIFO order; no instruction is dropped or duplicated.
- `in_insn` is sampled only when `in_valid & in_ready`.

## Structure
- Shared package `ebpf_pkg`, holding:
  - the ALU control enum (`ALU_ADD` = `4'h0` … `ALU_BE` = `4'he`), which `ALU` also uses;
  - class constants `CLASS_ALU` = `3'h4` and `CLASS_ALU64` = `3'h7`;
  - instruction field slice constants;
  - a packed struct for the decoded bundle.
- One sub-module, `ebpf_alu_insn_decoder`: purely combinational, 64-bit insn in, decoded struct out.
- The top-level module holds the two struct registers, the occupancy state and the counter.

## Test plan
- `64'h0000000F00000107` (ALU64 ADD K, dst 1, imm 15) → `alu_control = 0`, `is_32bit = 0`, `use_imm = 1`, `dst = 1`, `imm64 = 15`, `illegal = 0`, one cycle after accept.
- `64'h000000000000322c` (ALU MUL X, dst 2, src 3) → `alu_control = 2`, `is_32bit = 1`, `use_imm = 0`, `src = 3`.
- END vectors:
  - `64'h00000010000001dc` → `alu_control = 4'he`, `is_32bit = 0`, `imm64 = 16`.
  - `64'h00000020000001d4` → `alu_control = 4'hd`, `imm64 = 32`.
  - `64'h00000018000001d4` → `illegal = 1`.
- Immediate `0xFFFFFFFD` on `opcode 0x97` (ALU64 MOD K) → `imm64 = 64'hFFFFFFFFFFFFFFFD`.
- `opcode 0xe7` and `dst = 10` with `opcode 0x07` → `illegal = 1`. `illegal_count` steps 0 → 1 → 2, and only on handshake.
- Stream insns A–D with `out_ready` low for 3 cycles → exactly A, B accepted and `in_ready` falls after B. On release, A, B, C, D are delivered in order with no gap.
- Reset asserted while in TWO → next cycle `out_valid = 0`, `in_ready = 1`, `illegal_count = 0`.

Source files
------------

// File: rtl/ebpf_pkg.sv
// Shared eBPF CPU definitions: ALU control codes (also consumed by the ALU),
// instruction class constants, instruction field positions, the decoded
// bundle passed from decode to ALU, and the decode-stage occupancy encoding.
package ebpf_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_MUL  = 4'h2,
    ALU_DIV  = 4'h3,
    ALU_OR   = 4'h4,
    ALU_AND  = 4'h5,
    ALU_LSH  = 4'h6,
    ALU_RSH  = 4'h7,
    ALU_NEG  = 4'h8,
    ALU_MOD  = 4'h9,
    ALU_XOR  = 4'ha,
    ALU_MOV  = 4'hb,
    ALU_ARSH = 4'hc,
    ALU_LE   = 4'hd,
    ALU_BE   = 4'he
  } alu_ctrl_e;

  localparam logic [2:0] CLASS_ALU   = 3'h4;
  localparam logic [2:0] CLASS_ALU64 = 3'h7;

  // Operation nibble value of the byte-swap (END) instruction.
  localparam logic [3:0] OP_END = 4'hd;

  // Instruction field positions (LSB of each field).
  localparam int F_CLASS_LSB = 0;   // [2:0]
  localparam int F_SRCBIT    = 3;   // [3]   1 = operand B from register
  localparam int F_OP_LSB    = 4;   // [7:4]
  localparam int F_DST_LSB   = 8;   // [11:8]
  localparam int F_SRC_LSB   = 12;  // [15:12]
  localparam int F_OFF_LSB   = 16;  // [31:16]
  localparam int F_IMM_LSB   = 32;  // [63:32]

  typedef struct packed {
    logic        is_alu;
    alu_ctrl_e   alu_control;
    logic        is_32bit;
    logic        use_imm;
    logic [3:0]  dst_reg;
    logic [3:0]  src_reg;
    logic [63:0] imm64;
    logic        illegal;
  } decoded_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/ebpf_alu_insn_decoder.sv
// Combinational decoder for one eBPF instruction into the ALU control bundle.
// Ports:
//   insn  in  64  raw instruction
//   dec   out     decoded_t bundle (illegal only meaningful for ALU classes)
import ebpf_pkg::*;

module ebpf_alu_insn_decoder (
  input  logic [63:0] insn,
  output decoded_t    dec
);

  logic [2:0]  cls;
  logic        srcbit;
  logic [3:0]  op;
  logic [3:0]  dst;
  logic [3:0]  src;
  logic [31:0] imm;
  logic        is_end;
  logic        end_imm_ok;
  logic [15:0] unused_off;

  assign cls        = insn[F_CLASS_LSB +: 3];
  assign srcbit     = insn[F_SRCBIT];
  assign op         = insn[F_OP_LSB +: 4];
  assign dst        = insn[F_DST_LSB +: 4];
  assign src        = insn[F_SRC_LSB +: 4];
  assign imm        = insn[F_IMM_LSB +: 32];
  assign unused_off = insn[F_OFF_LSB +: 16];  // branch offset, not an ALU field

  assign is_end     = (op == OP_END);
  assign end_imm_ok = (imm == 32'd16) || (imm == 32'd32) || (imm == 32'd64);

  always_comb begin
    dec         = '0;
    dec.is_alu  = (cls == CLASS_ALU) || (cls == CLASS_ALU64);
    case (op)
      OP_END:       dec.alu_control = srcbit ? ALU_BE : ALU_LE;
      4'he, 4'hf:   dec.alu_control = ALU_ADD;  // no such op; flagged illegal below
      default:      dec.alu_control = alu_ctrl_e'(op);
    endcase
    // END carries its width in imm, so it always reads imm and has no 32-bit form.
    dec.is_32bit = ~is_end & (cls == CLASS_ALU);
    dec.use_imm  = is_end | ~srcbit;
    dec.dst_reg  = dst;
    dec.src_reg  = src;
    dec.imm64    = {{32{imm[31]}}, imm};
    dec.illegal  = dec.is_alu & ((op >= 4'he)
                              | (is_end & ((cls == CLASS_ALU64) | ~end_imm_ok))
                              | (dst > 4'd9)
                              | (srcbit & (src > 4'd10)));
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage feeding the ALU. Valid/ready on both sides with a
// two-entry skid buffer so in_ready comes straight from a flop while still
// sustaining one instruction per cycle.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake, in_insn 64-bit instruction
//   out_valid/out_ready   downstream handshake
//   out_*                 decoded fields of the head instruction
//   illegal_count         saturating count of illegal instructions delivered
import ebpf_pkg::*;

module alu_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_insn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_alu,
  output logic [3:0]  out_alu_control,
  output logic        out_is_32bit,
  output logic        out_use_imm,
  output logic [3:0]  out_dst_reg,
  output logic [3:0]  out_src_reg,
  output logic [63:0] out_imm64,
  output logic        out_illegal,
  output logic [15:0] illegal_count
);

  occ_e     state, state_nx;
  decoded_t dec, main_q, skid_q;
  logic     in_ready_q;
  logic     accept, hs;
  logic     main_ld_in, main_ld_skid, skid_ld;

  ebpf_alu_insn_decoder u_dec (
    .insn (in_insn),
    .dec  (dec)
  );

  assign accept   = in_valid & in_ready_q;
  assign hs       = out_valid & out_ready;
  assign in_ready = in_ready_q;

  // State register; in_ready is precomputed from the next state so it is a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nx;
      in_ready_q <= (state_nx != OCC_TWO);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      OCC_EMPTY: if (accept) state_nx = OCC_ONE;
      OCC_ONE: begin
        if (accept & ~hs)      state_nx = OCC_TWO;
        else if (~accept & hs) state_nx = OCC_EMPTY;
      end
      OCC_TWO:   if (hs) state_nx = OCC_ONE;
      default:   state_nx = OCC_EMPTY;
    endcase
  end

  always_comb begin
    out_valid    = (state != OCC_EMPTY);
    main_ld_in   = ((state == OCC_EMPTY) & accept) | ((state == OCC_ONE) & accept & hs);
    main_ld_skid = (state == OCC_TWO) & hs;
    skid_ld      = (state == OCC_ONE) & accept & ~hs;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q        <= '0;
      skid_q        <= '0;
      illegal_count <= '0;
    end else begin
      if (main_ld_in)        main_q <= dec;
      else if (main_ld_skid) main_q <= skid_q;
      if (skid_ld)           skid_q <= dec;
      if (hs && main_q.illegal && illegal_count != 16'hFFFF)
        illegal_count <= illegal_count + 16'd1;
    end
  end

  assign out_is_alu      = main_q.is_alu;
  assign out_alu_control = main_q.alu_control;
  assign out_is_32bit    = main_q.is_32bit;
  assign out_use_imm     = main_q.use_imm;
  assign out_dst_reg     = main_q.dst_reg;
  assign out_src_reg     = main_q.src_reg;
  assign out_imm64       = main_q.imm64;
  assign out_illegal     = main_q.illegal;

endmodule
